// File: rtl/mem_port_arbiter.sv
// Single memory bus port shared among NREQ requesters (0 = PTW, 1 = data, 2 = instruction).
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise the lowest index wins.
module mem_port_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*3-1:0]      req_size,
  input  logic [NREQ*DW/8-1:0]   req_strobe,
  input  logic [NREQ*DW-1:0]     req_data,
  output logic [NREQ-1:0]        resp_addr_ok,
  output logic [NREQ-1:0]        resp_data_ok,
  output logic [NREQ-1:0]        resp_err,
  output logic [DW-1:0]          resp_data,
  output logic                   m_valid,
  output logic [AW-1:0]          m_addr,
  output logic [2:0]             m_size,
  output logic [DW/8-1:0]        m_strobe,
  output logic [DW-1:0]          m_data,
  input  logic                   m_addr_ok,
  input  logic                   m_data_ok,
  input  logic [DW-1:0]          m_rdata,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  localparam int SW = DW / 8;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state_r;
  logic [NREQ-1:0]   grant_r;
  logic              busy_r;
  logic              m_valid_r;
  logic [AW-1:0]     m_addr_r;
  logic [2:0]        m_size_r;
  logic [SW-1:0]     m_strobe_r;
  logic [DW-1:0]     m_data_r;
  logic [WW-1:0]     wd_r;

  logic              any_req_s;
  logic [IW-1:0]     win_s;
  logic              done_s;
  logic              tmo_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0]     ptr_r;
  logic              found_s;
  int                rr_idx_s;

  // Round-robin winner: first valid requester at or after ptr_r + 1 (mod NREQ).
  always_comb begin
    win_s    = '0;
    found_s  = 1'b0;
    rr_idx_s = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx_s = (int'(ptr_r) + 1 + k) % NREQ;
      win_s    = (!found_s && req_valid[rr_idx_s]) ? IW'(rr_idx_s) : win_s;
      found_s  = found_s | req_valid[rr_idx_s];
    end
  end
`else
  // Fixed-priority winner: scanning downward leaves the lowest valid index.
  always_comb begin
    win_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      win_s = req_valid[k] ? IW'(k) : win_s;
    end
  end
`endif

  // Completion and watchdog qualifiers; a real m_data_ok always beats the timeout.
  always_comb begin
    any_req_s = |req_valid;
    done_s    = m_data_ok && ((state_r == S_DATA) || ((state_r == S_ADDR) && m_addr_ok));
    tmo_s     = (TIMEOUT != 0) && (state_r != S_IDLE) && (wd_r == WW'(TIMEOUT)) && !done_s;
  end

  // Response pulses routed only to the current owner; all zero while idle.
  always_comb begin
    resp_addr_ok = ((state_r == S_ADDR) && m_addr_ok) ? grant_r : '0;
    resp_data_ok = (done_s || tmo_s) ? grant_r : '0;
    resp_err     = tmo_s ? grant_r : '0;
    resp_data    = done_s ? m_rdata : '0;
  end

  // Arbitration FSM with registered grant, busy, memory-side request and watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      grant_r    <= '0;
      busy_r     <= 1'b0;
      m_valid_r  <= 1'b0;
      m_addr_r   <= '0;
      m_size_r   <= 3'd0;
      m_strobe_r <= '0;
      m_data_r   <= '0;
      wd_r       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_r      <= IW'(NREQ - 1);
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            state_r    <= S_ADDR;
            grant_r    <= ONE_HOT << win_s;
            busy_r     <= 1'b1;
            m_valid_r  <= 1'b1;
            m_addr_r   <= req_addr[int'(win_s)*AW +: AW];
            m_size_r   <= req_size[int'(win_s)*3 +: 3];
            m_strobe_r <= req_strobe[int'(win_s)*SW +: SW];
            m_data_r   <= req_data[int'(win_s)*DW +: DW];
            wd_r       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_r      <= win_s;
`endif
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ADDR, S_DATA: begin
          if (done_s || tmo_s) begin
            state_r    <= S_IDLE;
            grant_r    <= '0;
            busy_r     <= 1'b0;
            m_valid_r  <= 1'b0;
            m_addr_r   <= '0;
            m_size_r   <= 3'd0;
            m_strobe_r <= '0;
            m_data_r   <= '0;
            wd_r       <= '0;
          end else begin
            wd_r <= (TIMEOUT != 0) ? wd_r + WW'(1) : wd_r;
            if ((state_r == S_ADDR) && m_addr_ok) begin
              state_r <= S_DATA;
            end else begin
              state_r <= state_r;
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          grant_r    <= '0;
          busy_r     <= 1'b0;
          m_valid_r  <= 1'b0;
          m_addr_r   <= '0;
          m_size_r   <= 3'd0;
          m_strobe_r <= '0;
          m_data_r   <= '0;
          wd_r       <= '0;
        end
      endcase
    end
  end

  assign grant    = grant_r;
  assign busy     = busy_r;
  assign m_valid  = m_valid_r;
  assign m_addr   = m_addr_r;
  assign m_size   = m_size_r;
  assign m_strobe = m_strobe_r;
  assign m_data   = m_data_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT = 8); expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 64;
  localparam int DW   = 64;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*3-1:0]     req_size;
  logic [NREQ*DW/8-1:0]  req_strobe;
  logic [NREQ*DW-1:0]    req_data;
  logic [NREQ-1:0]       resp_addr_ok;
  logic [NREQ-1:0]       resp_data_ok;
  logic [NREQ-1:0]       resp_err;
  logic [DW-1:0]         resp_data;
  logic                  m_valid;
  logic [AW-1:0]         m_addr;
  logic [2:0]            m_size;
  logic [DW/8-1:0]       m_strobe;
  logic [DW-1:0]         m_data;
  logic                  m_addr_ok;
  logic                  m_data_ok;
  logic [DW-1:0]         m_rdata;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
    .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok), .resp_err(resp_err),
    .resp_data(resp_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_data(m_data),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] eg;
    int         idx;

    reset      = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_size   = '0;
    req_strobe = '0;
    req_data   = '0;
    m_addr_ok  = 1'b0;
    m_data_ok  = 1'b0;
    m_rdata    = '0;

    // Reset state
    #2 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_resp_data_ok", 64'(resp_data_ok), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single read from requester 2
    @(negedge clk);
    req_valid = 3'b100;
    req_addr[2*AW +: AW] = 64'h0000_0000_8000_0000;
    req_size[6 +: 3] = 3'd2;
    #1 chk("t1_idle_grant", 64'(grant), 64'd0);
    @(negedge clk); #1;
    chk("t1_grant", 64'(grant), 64'h4);
    chk("t1_m_valid", 64'(m_valid), 64'd1);
    chk("t1_m_addr", m_addr, 64'h8000_0000);
    chk("t1_m_size", 64'(m_size), 64'd2);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_no_addr_ok", 64'(resp_addr_ok), 64'd0);
    req_addr[2*AW +: AW] = 64'h1234;
    @(negedge clk);
    m_addr_ok = 1'b1;
    #1 chk("t1_addr_ok", 64'(resp_addr_ok), 64'h4);
    chk("t1_no_data_ok", 64'(resp_data_ok), 64'd0);
    @(negedge clk);
    m_addr_ok = 1'b0;
    #1 chk("t1_addr_held", m_addr, 64'h8000_0000);
    chk("t1_data_m_valid", 64'(m_valid), 64'd1);
    @(negedge clk);
    m_data_ok = 1'b1;
    m_rdata   = 64'hDEAD_BEEF;
    req_valid = 3'b000;
    #1 chk("t1_data_ok", 64'(resp_data_ok), 64'h4);
    chk("t1_resp_data", resp_data, 64'hDEAD_BEEF);
    chk("t1_no_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1 chk("t1_end_grant", 64'(grant), 64'd0);
    chk("t1_end_m_valid", 64'(m_valid), 64'd0);
    chk("t1_end_busy", 64'(busy), 64'd0);

    // All three requesting, combined handshake every transaction
    for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 64'(i + 1) * 64'h1000;
    req_valid = 3'b111;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      idx = RR ? (k % 3) : 0;
      eg  = 3'b001 << idx;
      m_addr_ok = 1'b1;
      m_data_ok = 1'b1;
      m_rdata   = 64'(k);
      #1 chk("t2_grant", 64'(grant), 64'(eg));
      chk("t2_addr_ok", 64'(resp_addr_ok), 64'(eg));
      chk("t2_data_ok", 64'(resp_data_ok), 64'(eg));
      chk("t2_m_addr", m_addr, 64'(idx + 1) * 64'h1000);
      @(negedge clk);
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      if (k == 3) req_valid = 3'b000;
      #1 chk("t2_bubble_grant", 64'(grant), 64'd0);
      chk("t2_bubble_data_ok", 64'(resp_data_ok), 64'd0);
      @(negedge clk);
    end

    // Watchdog: memory never answers
    req_valid = 3'b010;
    m_rdata   = 64'hFFFF;
    @(negedge clk); #1;
    chk("t3_grant", 64'(grant), 64'h2);
    chk("t3_g0_data_ok", 64'(resp_data_ok), 64'd0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk); #1;
      chk("t3_wait_data_ok", 64'(resp_data_ok), 64'd0);
    end
    @(negedge clk);
    req_valid = 3'b000;
    #1 chk("t3_tmo_data_ok", 64'(resp_data_ok), 64'h2);
    chk("t3_tmo_err", 64'(resp_err), 64'h2);
    chk("t3_tmo_data", resp_data, 64'd0);
    @(negedge clk); #1;
    chk("t3_after_m_valid", 64'(m_valid), 64'd0);
    chk("t3_after_grant", 64'(grant), 64'd0);

    // data_ok exactly in the timeout cycle; requester 0 is a write
    req_valid = 3'b001;
    req_strobe[0 +: 8] = 8'hFF;
    req_data[0 +: 64]  = 64'hA5A5_0000_1111_2222;
    @(negedge clk);
    m_addr_ok = 1'b1;
    #1 chk("t4_grant", 64'(grant), 64'h1);
    chk("t4_m_strobe", 64'(m_strobe), 64'hFF);
    chk("t4_m_data", m_data, 64'hA5A5_0000_1111_2222);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      m_addr_ok = 1'b0;
    end
    @(negedge clk);
    m_data_ok = 1'b1;
    m_rdata   = 64'hCAFE;
    req_valid = 3'b000;
    #1 chk("t4_data_ok", 64'(resp_data_ok), 64'h1);
    chk("t4_no_err", 64'(resp_err), 64'd0);
    chk("t4_resp_data", resp_data, 64'hCAFE);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1 chk("t4_end_busy", 64'(busy), 64'd0);

    // Asynchronous reset while in DATA
    req_valid = 3'b010;
    @(negedge clk);
    m_addr_ok = 1'b1;
    @(negedge clk);
    m_addr_ok = 1'b0;
    #1 chk("t5_pre_busy", 64'(busy), 64'd1);
    #1 reset = 1'b0;
    #1 chk("t5_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_grant", 64'(grant), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_data_ok", 64'(resp_data_ok), 64'd0);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 3'b111;
    @(negedge clk);
    m_addr_ok = 1'b1;
    m_data_ok = 1'b1;
    req_valid = 3'b000;
    #1 chk("t5_first_grant", 64'(grant), 64'h1);
    @(negedge clk);
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    #1 chk("t5_end_grant", 64'(grant), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
